miss_service_ctrl: RTL and testbench

MISS_SERVICE_CTRL -- requirements
Module: miss_service_ctrl

---
 rtl/miss_service_ctrl_pkg.sv | 22 ++
 rtl/miss_service_ctrl_line_beat_buffer.sv | 43 ++++
 rtl/miss_service_ctrl.sv | 141 ++++++++++++++
 tb/tb_miss_service_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/miss_service_ctrl_pkg.sv
// Shared cache package: default geometry, miss-service FSM encoding and width helpers.
package miss_service_ctrl_pkg;

  localparam int DEF_TAG_W  = 8;
  localparam int DEF_IDX_W  = 2;
  localparam int DEF_LINE_W = 128;
  localparam int DEF_BUS_W  = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WB      = 3'd1,
    ST_FILL    = 3'd2,
    ST_INSTALL = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Beat index width; a single-beat line still needs a 1-bit counter to exist.
  function automatic int beat_w(input int n_beats);
    return (n_beats > 1) ? $clog2(n_beats) : 1;
  endfunction

endpackage

// File: rtl/miss_service_ctrl_line_beat_buffer.sv
// Line-wide slot buffer with its own beat index; collects bus beats into a full cache line.
module line_beat_buffer
  import miss_service_ctrl_pkg::*;
#(
  parameter int LINE_W = DEF_LINE_W,
  parameter int BUS_W  = DEF_BUS_W,
  parameter int BEAT_W = beat_w(DEF_LINE_W / DEF_BUS_W)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              adv,
  input  logic              wr_en,
  input  logic [BUS_W-1:0]  wr_data,
  output logic [BEAT_W-1:0] beat,
  output logic              last,
  output logic [LINE_W-1:0] line
);

  localparam int                N_BEATS   = LINE_W / BUS_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

  logic [BEAT_W-1:0] beat_q;
  logic [LINE_W-1:0] line_q;

  // NOTE: the line store is reset like any other register (it is flops, not a RAM
  //       macro) so a fill aborted by reset can never expose stale beats.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  //       pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      beat_q <= '0;
      line_q <= '0;
    end else begin
      if (wr_en) line_q[beat_q*BUS_W +: BUS_W] <= wr_data;
      if (adv)   beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
    end
  end

  assign beat = beat_q;
  assign last = (beat_q == LAST_BEAT);
  assign line = line_q;

endmodule

// File: rtl/miss_service_ctrl.sv
// Cache miss service: optional dirty-victim write-back, line fill over a narrow bus, install.
module miss_service_ctrl
  import miss_service_ctrl_pkg::*;
#(
  parameter int TAG_W  = DEF_TAG_W,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int LINE_W = DEF_LINE_W,
  parameter int BUS_W  = DEF_BUS_W
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   ex_clr,
  input  logic                   ex_wb,
  input  logic [3:0]             way,
  input  logic [IDX_W-1:0]       index,
  input  logic [TAG_W-1:0]       victim_tag,
  input  logic [TAG_W-1:0]       req_tag,
  input  logic [LINE_W-1:0]      victim_data,
  output logic                   mem_req,
  output logic                   mem_rw,
  output logic [TAG_W+IDX_W+3:0] mem_addr,
  output logic [BUS_W-1:0]       mem_wdata,
  input  logic                   mem_ack,
  input  logic [BUS_W-1:0]       mem_rdata,
  output logic                   stall,
  output logic                   fill_we,
  output logic [3:0]             fill_way,
  output logic [IDX_W-1:0]       fill_index,
  output logic [TAG_W-1:0]       fill_tag,
  output logic [LINE_W-1:0]      fill_data,
  output logic                   fill_v,
  output logic                   fill_d,
  output logic                   done
);

  localparam int BEAT_W = beat_w(LINE_W / BUS_W);

  state_t            state_q, state_d;
  logic [3:0]        way_q;
  logic [IDX_W-1:0]  index_q;
  logic [TAG_W-1:0]  vtag_q, rtag_q;
  logic [LINE_W-1:0] victim_q;
  logic [BEAT_W-1:0] beat_cnt;
  logic              last_beat;
  logic [LINE_W-1:0] fill_line;

  logic capture, beat_adv;
  assign capture  = (state_q == ST_IDLE) && ex_clr;
  // Acks only count while a request is actually on the bus.
  assign beat_adv = ((state_q == ST_WB) || (state_q == ST_FILL)) && mem_ack;

  line_beat_buffer #(
    .LINE_W (LINE_W),
    .BUS_W  (BUS_W),
    .BEAT_W (BEAT_W)
  ) u_fill_buf (
    .clk     (clk),
    .clr     (clr),
    .adv     (beat_adv),
    .wr_en   ((state_q == ST_FILL) && mem_ack),
    .wr_data (mem_rdata),
    .beat    (beat_cnt),
    .last    (last_beat),
    .line    (fill_line)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // The dirty flag is consumed in the capture cycle itself: it picks WB vs FILL.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (ex_clr) state_d = ex_wb ? ST_WB : ST_FILL;
      ST_WB:      if (mem_ack && last_beat) state_d = ST_FILL;
      ST_FILL:    if (mem_ack && last_beat) state_d = ST_INSTALL;
      ST_INSTALL: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      way_q    <= '0;
      index_q  <= '0;
      vtag_q   <= '0;
      rtag_q   <= '0;
      victim_q <= '0;
    end else if (capture) begin
      way_q    <= way;
      index_q  <= index;
      vtag_q   <= victim_tag;
      rtag_q   <= req_tag;
      victim_q <= victim_data;
    end
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    mem_req    = 1'b0;
    mem_rw     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    stall      = 1'b1;
    fill_we    = 1'b0;
    fill_way   = '0;
    fill_index = '0;
    fill_tag   = '0;
    fill_data  = '0;
    fill_v     = 1'b0;
    fill_d     = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      ST_IDLE: stall = ex_clr && clr;
      ST_WB: begin
        mem_req   = 1'b1;
        mem_rw    = 1'b1;
        mem_addr  = {vtag_q, index_q, 4'b0000};
        mem_wdata = victim_q[beat_cnt*BUS_W +: BUS_W];
      end
      ST_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {rtag_q, index_q, 4'b0000};
      end
      ST_INSTALL: begin
        fill_we    = 1'b1;
        fill_way   = way_q;
        fill_index = index_q;
        fill_tag   = rtag_q;
        fill_data  = fill_line;
        fill_v     = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: stall = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_miss_service_ctrl.sv
// Directed bench for miss_service_ctrl with a bus-beat / install scoreboard.
module tb_miss_service_ctrl;

  logic         clk = 1'b0;
  logic         clr;
  logic         ex_clr, ex_wb;
  logic [3:0]   way;
  logic [1:0]   index;
  logic [7:0]   victim_tag, req_tag;
  logic [127:0] victim_data;
  logic         mem_req, mem_rw, mem_ack;
  logic [13:0]  mem_addr;
  logic [31:0]  mem_wdata, mem_rdata;
  logic         stall, fill_we, fill_v, fill_d, done;
  logic [3:0]   fill_way;
  logic [1:0]   fill_index;
  logic [7:0]   fill_tag;
  logic [127:0] fill_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rw;
    logic [13:0] addr;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic [3:0]   way;
    logic [1:0]   index;
    logic [7:0]   tag;
    logic [127:0] data;
  } inst_t;

  beat_t bus_q[$];
  inst_t inst_q[$];

  miss_service_ctrl dut (
    .clk         (clk),
    .clr         (clr),
    .ex_clr      (ex_clr),
    .ex_wb       (ex_wb),
    .way         (way),
    .index       (index),
    .victim_tag  (victim_tag),
    .req_tag     (req_tag),
    .victim_data (victim_data),
    .mem_req     (mem_req),
    .mem_rw      (mem_rw),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .stall       (stall),
    .fill_we     (fill_we),
    .fill_way    (fill_way),
    .fill_index  (fill_index),
    .fill_tag    (fill_tag),
    .fill_data   (fill_data),
    .fill_v      (fill_v),
    .fill_d      (fill_d),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_stall"},   stall,   1'b0);
    check({tag, "_mem_req"}, mem_req, 1'b0);
    check({tag, "_fill_we"}, fill_we, 1'b0);
    check({tag, "_done"},    done,    1'b0);
  endtask

  // Called one time unit after a rising edge with the DUT in IDLE; returns likewise.
  task automatic start_miss(input logic wb, input logic [3:0] w, input logic [1:0] idx,
                            input logic [7:0] vt, input logic [7:0] rt,
                            input logic [127:0] vdata, input logic [31:0] rbase);
    beat_t        b;
    inst_t        e;
    logic [127:0] line;
    line = '0;
    if (wb) begin
      for (int i = 0; i < 4; i++) begin
        b.rw = 1'b1; b.addr = {vt, idx, 4'b0000}; b.data = vdata[i*32 +: 32];
        bus_q.push_back(b);
      end
    end
    for (int i = 0; i < 4; i++) begin
      b.rw = 1'b0; b.addr = {rt, idx, 4'b0000}; b.data = rbase + 32'(i);
      bus_q.push_back(b);
      line[i*32 +: 32] = rbase + 32'(i);
    end
    e.way = w; e.index = idx; e.tag = rt; e.data = line;
    inst_q.push_back(e);
    ex_clr = 1'b1; ex_wb = wb; way = w; index = idx;
    victim_tag = vt; req_tag = rt; victim_data = vdata;
    #1 check("stall_capture_comb", stall, 1'b1);
    @(posedge clk); #1;
    ex_clr = 1'b0; ex_wb = 1'b0; way = '0; index = '0; victim_tag = '0; req_tag = '0;
  endtask

  // Plays memory: acks after 'gap' wait cycles per beat; optional ex_clr pulse mid-transfer.
  task automatic run_service(input int gap, input int exp_lat, input bit pulse);
    int    k = 1, wait_cnt = 0, lat = -1, done_k = -1;
    bit    seen_done = 1'b0;
    inst_t e;
    while (!seen_done && k < 200) begin
      check("stall_busy", stall, 1'b1);
      if (fill_we) begin
        check("mem_req_install", mem_req, 1'b0);
        if (inst_q.size() == 0) check("fill_we_unexpected", 1'b1, 1'b0);
        else begin
          e = inst_q.pop_front();
          check("fill_data",  fill_data,  e.data);
          check("fill_way",   fill_way,   e.way);
          check("fill_index", fill_index, e.index);
          check("fill_tag",   fill_tag,   e.tag);
          check("fill_v",     fill_v,     1'b1);
          check("fill_d",     fill_d,     1'b0);
          lat = k;
        end
      end
      if (done) begin
        seen_done = 1'b1;
        done_k    = k;
        check("mem_req_done", mem_req, 1'b0);
      end
      mem_ack = 1'b0;
      ex_clr  = pulse && (k == 2);
      ex_wb   = pulse && (k == 2);
      if (mem_req) begin
        if (bus_q.size() == 0) check("bus_unexpected", 1'b1, 1'b0);
        else begin
          check("mem_rw",   mem_rw,   bus_q[0].rw);
          check("mem_addr", mem_addr, bus_q[0].addr);
          if (bus_q[0].rw) check("mem_wdata", mem_wdata, bus_q[0].data);
          if (wait_cnt == gap) begin
            mem_ack   = 1'b1;
            mem_rdata = bus_q[0].rw ? $urandom : bus_q[0].data;
            void'(bus_q.pop_front());
            wait_cnt  = 0;
          end else wait_cnt++;
        end
      end
      @(posedge clk); #1;
      k++;
    end
    mem_ack = 1'b0; ex_clr = 1'b0; ex_wb = 1'b0;
    check("done_seen", seen_done, 1'b1);
    check("latency", lat, exp_lat);
    check("done_after_install", done_k, lat + 1);
    check("bus_q_drained", bus_q.size(), 0);
    check("inst_q_drained", inst_q.size(), 0);
    check("stall_after_done", stall, 1'b0);
    check("done_single", done, 1'b0);
  endtask

  initial begin
    clr = 1'b0; ex_clr = 1'b0; ex_wb = 1'b0; way = '0; index = '0;
    victim_tag = '0; req_tag = '0; victim_data = '0; mem_ack = 1'b0; mem_rdata = '0;
    #2;
    check_quiet("reset");
    check("reset_mem_addr",   mem_addr,   14'h0);
    check("reset_mem_wdata",  mem_wdata,  32'h0);
    check("reset_mem_rw",     mem_rw,     1'b0);
    check("reset_fill_data",  fill_data,  128'h0);
    check("reset_fill_v",     fill_v,     1'b0);
    @(negedge clk) clr = 1'b1;
    @(posedge clk); #1;

    // Clean miss, ack every beat: reads at 0F20, install after 1+N cycles.
    start_miss(1'b0, 4'b0100, 2'd2, 8'h00, 8'h3C, 128'h0, 32'd1);
    run_service(0, 5, 1'b0);

    // Dirty miss: four LSB-first writes at 2950, four reads, install after 1+2N.
    start_miss(1'b1, 4'b0010, 2'd1, 8'hA5, 8'h5A,
               128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 32'h1000_0000);
    run_service(0, 9, 1'b0);

    // Backpressure: three idle cycles before every ack; request must hold still.
    start_miss(1'b1, 4'b1000, 2'd3, 8'h12, 8'h34,
               128'h0F0E0D0C_0B0A0908_07060504_03020100, 32'hCAFE_0000);
    run_service(3, 33, 1'b0);

    // Spurious write-back flag and stray ack in IDLE must start nothing.
    ex_wb = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      #1 check_quiet("spurious_idle");
      @(posedge clk); #1;
    end
    ex_wb = 1'b0; mem_ack = 1'b0;

    // ex_clr pulse during WB is dropped: one transfer, one done, then quiet.
    start_miss(1'b1, 4'b0001, 2'd0, 8'h81, 8'h18,
               128'h44444444_33333333_22222222_11111111, 32'h0000_0A00);
    run_service(0, 9, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_quiet("post_pulse");
      @(posedge clk); #1;
    end

    // Reset after two fill beats: everything drops at once, no install follows.
    start_miss(1'b0, 4'b0001, 2'd3, 8'h00, 8'h77, 128'h0, 32'h0000_0100);
    for (int i = 0; i < 2; i++) begin
      check("pre_reset_mem_req",  mem_req,  1'b1);
      check("pre_reset_mem_addr", mem_addr, bus_q[0].addr);
      mem_ack = 1'b1; mem_rdata = bus_q[0].data;
      void'(bus_q.pop_front());
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    check("mid_fill_mem_req", mem_req, 1'b1);
    #2 clr = 1'b0;
    #1 check_quiet("async_reset");
    check("async_reset_mem_addr", mem_addr, 14'h0);
    bus_q.delete();
    inst_q.delete();
    @(negedge clk) clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_quiet("post_reset");
    end

    // Fresh clean miss: beat counter must restart at slot 0 after the abort.
    start_miss(1'b0, 4'b0010, 2'd1, 8'h00, 8'hC3, 128'h0, 32'h5555_0000);
    run_service(0, 5, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
